// File: rtl/mem_lock_arbiter_if.sv
// Bundle of lock-request, memory-port and read-data signals shared by the
// Mem sub-SICs and the data-memory lock arbiter.
interface mem_lock_arbiter_if #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = 8
);
    logic [NUM_REQ-1:0]               req;
    logic [NUM_REQ-1:0][ID_WIDTH-1:0] req_issue_id;
    logic [NUM_REQ-1:0]               release_lock;
    logic [NUM_REQ-1:0][29:0]         req_addr;
    logic [NUM_REQ-1:0][31:0]         req_wdata;
    logic [NUM_REQ-1:0]               req_wen;
    logic [NUM_REQ-1:0]               grant;
    logic [29:0]                      mem_addr;
    logic [31:0]                      mem_wdata;
    logic                             mem_wen;
    logic [31:0]                      mem_rdata;
    logic [31:0]                      rdata;
    logic                             busy;

    // Requester side (sub-SICs and memory model).
    modport master (
        output req, req_issue_id, release_lock, req_addr, req_wdata, req_wen, mem_rdata,
        input  grant, mem_addr, mem_wdata, mem_wen, rdata, busy
    );

    // Arbiter side.
    modport slave (
        input  req, req_issue_id, release_lock, req_addr, req_wdata, req_wen, mem_rdata,
        output grant, mem_addr, mem_wdata, mem_wen, rdata, busy
    );
endinterface

// File: rtl/mem_lock_arbiter.sv
// Oldest-first, non-preemptive lock arbiter for the single data-memory port.
// The registered owner gets a combinational grant; release or abort frees the
// lock and the oldest other requester is registered at the same edge.
module mem_lock_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    mem_lock_arbiter_if.slave bus
);
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {StIdle, StOwned} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] own_idx_q, own_idx_d;

    logic            cand_any;
    logic [IdxW-1:0] win_idx;
    logic            own_free;

    // Wrap-aware age compare: a is older than b when (a - b) is negative.
    function automatic logic older(input logic [ID_WIDTH-1:0] a, input logic [ID_WIDTH-1:0] b);
        logic [ID_WIDTH-1:0] diff;
        diff = a - b;
        return diff[ID_WIDTH-1];
    endfunction

    // Linear oldest-so-far scan; strict compare keeps the lower index on ties.
    always_comb begin
        cand_any = 1'b0;
        win_idx  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (bus.req[i] && !(state_q == StOwned && own_idx_q == IdxW'(i))) begin
                if (!cand_any || older(bus.req_issue_id[i], bus.req_issue_id[win_idx])) begin
                    win_idx = IdxW'(i);
                end
                cand_any = 1'b1;
            end
        end
    end

    // Grant decode and memory-port mux from the registered owner.
    always_comb begin
        bus.grant     = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wen   = 1'b0;
        if (state_q == StOwned) begin
            bus.grant[own_idx_q] = bus.req[own_idx_q];
            bus.mem_addr         = bus.req_addr[own_idx_q];
            bus.mem_wdata        = bus.req_wdata[own_idx_q];
            bus.mem_wen          = bus.req_wen[own_idx_q] && bus.req[own_idx_q];
        end
        bus.rdata = bus.mem_rdata;
        bus.busy  = (state_q == StOwned);
    end

    // Release with grant and abort (owner dropped req) both free the lock.
    assign own_free = !bus.req[own_idx_q] || bus.release_lock[own_idx_q];

    // Next-state: claim or hand off to the winner when idle or freed, else hold.
    always_comb begin
        state_d   = state_q;
        own_idx_d = own_idx_q;
        if (state_q == StIdle || own_free) begin
            if (cand_any) begin
                state_d   = StOwned;
                own_idx_d = win_idx;
            end else begin
                state_d   = StIdle;
            end
        end
    end

    // Owner state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            own_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            own_idx_q <= own_idx_d;
        end
    end
endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Table-driven bench for mem_lock_arbiter: one row per cycle, expected outputs
// queued on drive and compared mid-cycle, plus a reset-while-granted sequence.
module tb_mem_lock_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mem_lock_arbiter_if #(.NUM_REQ(4), .ID_WIDTH(8)) bus ();

    mem_lock_arbiter #(.NUM_REQ(4), .ID_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      req;
        logic [3:0][7:0] id;
        logic [3:0]      rel;
        logic [3:0]      wen;
        logic [3:0]      e_grant;
        logic            e_busy;
        int              e_own;
        logic            e_wen;
    } vec_t;

    typedef struct {
        logic [3:0]  grant;
        logic        busy;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic        wen;
        logic [31:0] rdata;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    logic [3:0][29:0] addr_tab;
    logic [3:0][31:0] wdata_tab;

    function automatic vec_t mk(input logic [3:0] req, input logic [31:0] ids,
                                input logic [3:0] rel, input logic [3:0] wen,
                                input logic [3:0] e_grant, input logic e_busy,
                                input int e_own, input logic e_wen);
        vec_t v;
        v.req = req; v.id = ids; v.rel = rel; v.wen = wen;
        v.e_grant = e_grant; v.e_busy = e_busy; v.e_own = e_own; v.e_wen = e_wen;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.req = '0; bus.req_issue_id = '0; bus.release_lock = '0; bus.req_wen = '0;
    endtask

    initial begin
        exp_t e;
        addr_tab  = {30'h30, 30'h3FF, 30'h10, 30'h20};
        wdata_tab = {32'h11110003, 32'h12345678, 32'h11110001, 32'hCAFE0000};
        bus.req_addr  = addr_tab;
        bus.req_wdata = wdata_tab;
        bus.mem_rdata = 32'hDEADBEEF;
        drive_idle();

        // req, ids {3,2,1,0}, rel, wen, exp grant, busy, owner, mem_wen
        vt.push_back(mk(4'b0010, 32'h00_00_05_00, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vt.push_back(mk(4'b0010, 32'h00_00_05_00, 4'b0010, 4'b0000, 4'b0010, 1, 1, 0));
        vt.push_back(mk(4'b0000, 32'h0,           4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vt.push_back(mk(4'b0101, 32'h00_FE_00_02, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vt.push_back(mk(4'b0101, 32'h00_FE_00_02, 4'b0100, 4'b0000, 4'b0100, 1, 2, 0));
        vt.push_back(mk(4'b0001, 32'h00_FE_00_02, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0));
        vt.push_back(mk(4'b0000, 32'h0,           4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vt.push_back(mk(4'b1000, 32'h0A_00_00_00, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vt.push_back(mk(4'b1001, 32'h0A_00_00_08, 4'b0000, 4'b0000, 4'b1000, 1, 3, 0));
        vt.push_back(mk(4'b1001, 32'h0A_00_00_08, 4'b0001, 4'b0000, 4'b1000, 1, 3, 0));
        vt.push_back(mk(4'b1001, 32'h0A_00_00_08, 4'b0000, 4'b0000, 4'b1000, 1, 3, 0));
        vt.push_back(mk(4'b1001, 32'h0A_00_00_08, 4'b1000, 4'b0000, 4'b1000, 1, 3, 0));
        vt.push_back(mk(4'b0001, 32'h0A_00_00_08, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0));
        vt.push_back(mk(4'b0000, 32'h0,           4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vt.push_back(mk(4'b0100, 32'h00_14_00_00, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vt.push_back(mk(4'b0110, 32'h00_14_15_00, 4'b0000, 4'b0100, 4'b0100, 1, 2, 1));
        vt.push_back(mk(4'b0010, 32'h00_14_15_00, 4'b0000, 4'b0100, 4'b0000, 1, 2, 0));
        vt.push_back(mk(4'b0010, 32'h00_14_15_00, 4'b0010, 4'b0000, 4'b0010, 1, 1, 0));
        vt.push_back(mk(4'b0000, 32'h0,           4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vt.push_back(mk(4'b0101, 32'h00_28_00_30, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0));
        vt.push_back(mk(4'b0101, 32'h00_28_00_30, 4'b0100, 4'b0101, 4'b0100, 1, 2, 1));
        vt.push_back(mk(4'b0001, 32'h00_28_00_30, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0));
        vt.push_back(mk(4'b0000, 32'h0,           4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vt.push_back(mk(4'b0110, 32'h00_40_40_00, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vt.push_back(mk(4'b0110, 32'h00_40_40_00, 4'b0010, 4'b0000, 4'b0010, 1, 1, 0));
        vt.push_back(mk(4'b0100, 32'h00_40_40_00, 4'b0100, 4'b0000, 4'b0100, 1, 2, 0));
        vt.push_back(mk(4'b0000, 32'h0,           4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vt.push_back(mk(4'b0010, 32'h00_00_07_00, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vt.push_back(mk(4'b0010, 32'h00_00_07_00, 4'b0010, 4'b0000, 4'b0010, 1, 1, 0));
        vt.push_back(mk(4'b0010, 32'h00_00_07_00, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        vt.push_back(mk(4'b0010, 32'h00_00_07_00, 4'b0010, 4'b0000, 4'b0010, 1, 1, 0));
        vt.push_back(mk(4'b0000, 32'h0,           4'b0000, 4'b0000, 4'b0000, 0, 0, 0));

        // Reset state: all memory outputs and grant zero, rdata passes through.
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_mem_wen", 32'(bus.mem_wen), 32'h0);
        check("rst_rdata", bus.rdata, 32'hDEADBEEF);
        rst_n = 1'b1;

        for (int k = 0; k < vt.size(); k++) begin
            exp_t got;
            @(posedge clk);
            #1;
            bus.req           = vt[k].req;
            bus.req_issue_id  = vt[k].id;
            bus.release_lock  = vt[k].rel;
            bus.req_wen       = vt[k].wen;
            bus.mem_rdata     = (k == 0 || k == 1) ? 32'hDEADBEEF : 32'hBEEF0000 + 32'(k);
            e.grant = vt[k].e_grant;
            e.busy  = vt[k].e_busy;
            e.addr  = vt[k].e_busy ? addr_tab[vt[k].e_own] : 30'h0;
            e.wdata = vt[k].e_busy ? wdata_tab[vt[k].e_own] : 32'h0;
            e.wen   = vt[k].e_wen;
            e.rdata = bus.mem_rdata;
            sb.push_back(e);
            @(negedge clk);
            got = sb.pop_front();
            check($sformatf("row%0d_grant", k), 32'(bus.grant), 32'(got.grant));
            check($sformatf("row%0d_busy", k), 32'(bus.busy), 32'(got.busy));
            check($sformatf("row%0d_mem_addr", k), 32'(bus.mem_addr), 32'(got.addr));
            check($sformatf("row%0d_mem_wdata", k), bus.mem_wdata, got.wdata);
            check($sformatf("row%0d_mem_wen", k), 32'(bus.mem_wen), 32'(got.wen));
            check($sformatf("row%0d_rdata", k), bus.rdata, got.rdata);
        end

        // Reset while granted: outputs drop at once, held req re-granted after.
        @(posedge clk);
        #1;
        drive_idle();
        bus.req = 4'b0010;
        bus.req_wen = 4'b0010;
        bus.req_issue_id = 32'h00_00_09_00;
        @(posedge clk);
        #1;
        check("pre_rst_grant", 32'(bus.grant), 32'h2);
        check("pre_rst_mem_wen", 32'(bus.mem_wen), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_grant", 32'(bus.grant), 32'h0);
        check("midrst_busy", 32'(bus.busy), 32'h0);
        check("midrst_mem_wen", 32'(bus.mem_wen), 32'h0);
        check("midrst_mem_addr", 32'(bus.mem_addr), 32'h0);
        check("midrst_mem_wdata", bus.mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_grant0", 32'(bus.grant), 32'h0);
        @(posedge clk);
        #1;
        check("postrst_grant1", 32'(bus.grant), 32'h2);
        check("postrst_mem_addr", 32'(bus.mem_addr), 32'h10);
        drive_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
